// File: rtl/resolve_arbiter.sv
// resolve_arbiter: collects NUM_CH branch resolves, redirects on the oldest mispredict,
// filters wrong-path results and queues predictor updates.
module resolve_arbiter #(
    parameter int NUM_CH    = 2,
    parameter int PC_W      = 32,
    parameter int ROB_IDX_W = 5,
    parameter int UPD_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CH-1:0]           fu_valid,
    input  logic [NUM_CH-1:0]           fu_taken,
    input  logic [NUM_CH*PC_W-1:0]      fu_src,
    input  logic [NUM_CH*PC_W-1:0]      fu_dst,
    input  logic [NUM_CH-1:0]           fu_pred_taken,
    input  logic [NUM_CH*PC_W-1:0]      fu_pred_dst,
    input  logic [NUM_CH*ROB_IDX_W-1:0] fu_rob_idx,
    output logic                        fu_ready,
    input  logic [ROB_IDX_W-1:0]        rob_head,
    input  logic                        recover_done,
    output logic                        redir_valid,
    output logic [PC_W-1:0]             redir_dst,
    output logic [ROB_IDX_W-1:0]        redir_rob_idx,
    output logic                        upd_valid,
    output logic [PC_W-1:0]             upd_src,
    output logic [PC_W-1:0]             upd_dst,
    output logic                        upd_taken,
    output logic                        upd_right,
    input  logic                        upd_ready
);
    localparam int AW = $clog2(UPD_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {IDLE, SQUASH} state_t;
    typedef struct packed {
        logic [PC_W-1:0] src;
        logic [PC_W-1:0] dst;
        logic            taken;
        logic            right;
    } ent_t;

    state_t               state, state_nxt;
    logic                 squashing;
    logic [ROB_IDX_W-1:0] bnd_idx, bnd_age;
    logic [ROB_IDX_W-1:0] age [NUM_CH];
    logic [NUM_CH-1:0]    acc, right, surv;
    logic                 have_mis;
    logic [ROB_IDX_W-1:0] sel_age, sel_idx;
    logic [PC_W-1:0]      sel_dst;
    logic [AW-1:0]        wr_off [NUM_CH];
    logic [CW-1:0]        count, npush;
    logic [AW-1:0]        wr_ptr, rd_ptr;
    ent_t                 mem [UPD_DEPTH];
    ent_t                 head;
    logic                 pop;

    assign fu_ready = count <= CW'(UPD_DEPTH - NUM_CH);
    assign bnd_age  = bnd_idx - rob_head;

    // Ages are relative to rob_head so the modulo wrap of ROB indices orders correctly
    always_comb begin
        have_mis = 1'b0;
        sel_age  = '0;
        sel_idx  = '0;
        sel_dst  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            age[i]   = fu_rob_idx[i*ROB_IDX_W +: ROB_IDX_W] - rob_head;
            right[i] = fu_taken[i] == fu_pred_taken[i] && fu_dst[i*PC_W +: PC_W] == fu_pred_dst[i*PC_W +: PC_W];
            acc[i]   = fu_valid[i] && fu_ready && !(squashing && age[i] > bnd_age);
            if (acc[i] && !right[i] && (!have_mis || age[i] < sel_age)) begin
                have_mis = 1'b1;
                sel_age  = age[i];
                sel_idx  = fu_rob_idx[i*ROB_IDX_W +: ROB_IDX_W];
                sel_dst  = fu_dst[i*PC_W +: PC_W];
            end
        end
    end

    // Survivors exclude same-cycle branches younger than the selected mispredict
    always_comb begin
        npush = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            surv[i]   = acc[i] && !(have_mis && age[i] > sel_age);
            wr_off[i] = npush[AW-1:0];
            npush     = npush + CW'(surv[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = have_mis ? SQUASH : (state == SQUASH && recover_done) ? IDLE : state;
    end

    always_comb begin
        squashing = state == SQUASH;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bnd_idx       <= '0;
            redir_valid   <= 1'b0;
            redir_dst     <= '0;
            redir_rob_idx <= '0;
        end else begin
            redir_valid <= have_mis;
            if (have_mis) begin
                bnd_idx       <= sel_idx;
                redir_dst     <= sel_dst;
                redir_rob_idx <= sel_idx;
            end
        end
    end

    assign pop = upd_valid && upd_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + npush[AW-1:0];
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + npush - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++)
            if (surv[i])
                mem[wr_ptr + wr_off[i]] <= {fu_src[i*PC_W +: PC_W], fu_dst[i*PC_W +: PC_W], fu_taken[i], right[i]};
    end

    assign head      = mem[rd_ptr];
    assign upd_valid = count != '0;
    assign upd_src   = upd_valid ? head.src : '0;
    assign upd_dst   = upd_valid ? head.dst : '0;
    assign upd_taken = upd_valid && head.taken;
    assign upd_right = upd_valid && head.right;
endmodule

// File: tb/tb_resolve_arbiter.sv
// tb_resolve_arbiter: directed scenarios plus random traffic against a queue-based reference model.
module tb_resolve_arbiter;
    localparam int NUM_CH = 2;
    localparam int PC_W   = 32;
    localparam int RW     = 5;
    localparam int DEPTH  = 8;
    localparam int MASK   = (1 << RW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NUM_CH-1:0]      fu_valid, fu_taken, fu_pred_taken;
    logic [NUM_CH*PC_W-1:0] fu_src, fu_dst, fu_pred_dst;
    logic [NUM_CH*RW-1:0]   fu_rob_idx;
    logic                   fu_ready;
    logic [RW-1:0]          rob_head;
    logic                   recover_done;
    logic                   redir_valid;
    logic [PC_W-1:0]        redir_dst;
    logic [RW-1:0]          redir_rob_idx;
    logic                   upd_valid;
    logic [PC_W-1:0]        upd_src, upd_dst;
    logic                   upd_taken, upd_right, upd_ready;

    resolve_arbiter #(.NUM_CH(NUM_CH), .PC_W(PC_W), .ROB_IDX_W(RW), .UPD_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .fu_valid(fu_valid), .fu_taken(fu_taken), .fu_src(fu_src), .fu_dst(fu_dst),
        .fu_pred_taken(fu_pred_taken), .fu_pred_dst(fu_pred_dst), .fu_rob_idx(fu_rob_idx),
        .fu_ready(fu_ready), .rob_head(rob_head), .recover_done(recover_done),
        .redir_valid(redir_valid), .redir_dst(redir_dst), .redir_rob_idx(redir_rob_idx),
        .upd_valid(upd_valid), .upd_src(upd_src), .upd_dst(upd_dst),
        .upd_taken(upd_taken), .upd_right(upd_right), .upd_ready(upd_ready)
    );

    typedef struct packed {
        logic [31:0] src;
        logic [31:0] dst;
        logic        taken;
        logic        right;
    } ent_t;

    ent_t        q[$];
    bit          m_sq, m_rv;
    int          m_bnd, m_ridx;
    logic [31:0] m_rdst;
    int          checks = 0;
    int          errors = 0;
    logic [RW-1:0] base;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: ages in plain modular int arithmetic, FIFO as a queue
    task automatic model_step();
        int  age[NUM_CH];
        bit  acc[NUM_CH];
        bit  rt[NUM_CH];
        int  best, best_age, bage;
        bit  rdy;
        if (!rst_n) begin
            q.delete();
            m_sq = 0; m_rv = 0; m_bnd = 0; m_ridx = 0; m_rdst = '0;
            return;
        end
        rdy = (DEPTH - q.size()) >= NUM_CH;
        if (q.size() > 0 && upd_ready) void'(q.pop_front());
        bage = (m_bnd - int'(rob_head)) & MASK;
        best = -1;
        best_age = MASK + 1;
        for (int i = 0; i < NUM_CH; i++) begin
            age[i] = (int'(fu_rob_idx[i*RW +: RW]) - int'(rob_head)) & MASK;
            acc[i] = fu_valid[i] && rdy && !(m_sq && age[i] > bage);
            rt[i]  = (fu_taken[i] == fu_pred_taken[i]) && (fu_dst[i*PC_W +: PC_W] == fu_pred_dst[i*PC_W +: PC_W]);
            if (acc[i] && !rt[i] && age[i] < best_age) begin
                best = i;
                best_age = age[i];
            end
        end
        for (int i = 0; i < NUM_CH; i++)
            if (acc[i] && !(best >= 0 && age[i] > best_age))
                q.push_back('{fu_src[i*PC_W +: PC_W], fu_dst[i*PC_W +: PC_W], fu_taken[i], rt[i]});
        m_rv = best >= 0;
        if (best >= 0) begin
            m_rdst = fu_dst[best*PC_W +: PC_W];
            m_ridx = int'(fu_rob_idx[best*RW +: RW]);
            m_bnd  = m_ridx;
            m_sq   = 1;
        end else if (m_sq && recover_done) m_sq = 0;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        chk("redir_valid", 64'(redir_valid), 64'(m_rv));
        if (m_rv) begin
            chk("redir_dst", 64'(redir_dst), 64'(m_rdst));
            chk("redir_rob_idx", 64'(redir_rob_idx), 64'(m_ridx));
        end
        chk("fu_ready", 64'(fu_ready), 64'((DEPTH - q.size()) >= NUM_CH));
        chk("upd_valid", 64'(upd_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            chk("upd_src", 64'(upd_src), 64'(q[0].src));
            chk("upd_dst", 64'(upd_dst), 64'(q[0].dst));
            chk("upd_taken", 64'(upd_taken), 64'(q[0].taken));
            chk("upd_right", 64'(upd_right), 64'(q[0].right));
        end
    end

    task automatic clr();
        fu_valid = '0; fu_taken = '0; fu_pred_taken = '0;
        fu_src = '0; fu_dst = '0; fu_pred_dst = '0; fu_rob_idx = '0;
        recover_done = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clr();
    endtask

    task automatic set_ch(int i, logic tk, logic pt, logic [31:0] s, logic [31:0] d, logic [31:0] pd, logic [RW-1:0] idx);
        fu_valid[i] = 1'b1;
        fu_taken[i] = tk;
        fu_pred_taken[i] = pt;
        fu_src[i*PC_W +: PC_W] = s;
        fu_dst[i*PC_W +: PC_W] = d;
        fu_pred_dst[i*PC_W +: PC_W] = pd;
        fu_rob_idx[i*RW +: RW] = idx;
    endtask

    initial begin
        clr();
        upd_ready = 1'b0;
        rob_head = '0;
        tick(); tick();
        chk("rst fu_ready", 64'(fu_ready), 64'd1);
        chk("rst upd_valid", 64'(upd_valid), 64'd0);
        chk("rst redir_valid", 64'(redir_valid), 64'd0);
        rst_n = 1'b1;
        // correct not-taken branch
        set_ch(0, 0, 0, 32'h100, 32'h104, 32'h104, 5'd0);
        tick();
        chk("t1 redir_valid", 64'(redir_valid), 64'd0);
        chk("t1 upd_valid", 64'(upd_valid), 64'd1);
        chk("t1 upd_src", 64'(upd_src), 64'h100);
        chk("t1 upd_dst", 64'(upd_dst), 64'h104);
        chk("t1 upd_taken", 64'(upd_taken), 64'd0);
        chk("t1 upd_right", 64'(upd_right), 64'd1);
        upd_ready = 1'b1;
        tick();
        upd_ready = 1'b0;
        // dual mispredict across the index wrap
        rob_head = 5'd30;
        set_ch(0, 1, 0, 32'h200, 32'h240, 32'h204, 5'd1);
        set_ch(1, 1, 0, 32'h300, 32'h380, 32'h304, 5'd31);
        tick();
        chk("t2 redir_valid", 64'(redir_valid), 64'd1);
        chk("t2 redir_rob_idx", 64'(redir_rob_idx), 64'd31);
        chk("t2 redir_dst", 64'(redir_dst), 64'h380);
        chk("t2 upd_src", 64'(upd_src), 64'h300);
        chk("t2 upd_right", 64'(upd_right), 64'd0);
        upd_ready = 1'b1;
        tick();
        chk("t2 single entry", 64'(upd_valid), 64'd0);
        recover_done = 1'b1;
        tick();
        // squash filter
        rob_head = 5'd8;
        set_ch(0, 1, 0, 32'h400, 32'h600, 32'h404, 5'd10);
        tick();
        chk("t3 redir idx10", 64'(redir_rob_idx), 64'd10);
        set_ch(0, 0, 0, 32'h500, 32'h504, 32'h504, 5'd12);
        tick();
        chk("t3 idx12 dropped", 64'(upd_valid), 64'd0);
        set_ch(0, 1, 0, 32'h480, 32'h680, 32'h484, 5'd9);
        tick();
        chk("t3 redir_valid idx9", 64'(redir_valid), 64'd1);
        chk("t3 redir idx9", 64'(redir_rob_idx), 64'd9);
        recover_done = 1'b1;
        tick();
        set_ch(0, 0, 0, 32'h500, 32'h504, 32'h504, 5'd12);
        tick();
        chk("t3 idx12 accepted", 64'(upd_valid), 64'd1);
        chk("t3 idx12 src", 64'(upd_src), 64'h500);
        tick();
        // recover_done loses to a same-cycle redirect
        rob_head = 5'd0;
        set_ch(0, 1, 0, 32'h800, 32'h900, 32'h804, 5'd20);
        tick();
        recover_done = 1'b1;
        set_ch(0, 1, 0, 32'h810, 32'h910, 32'h814, 5'd5);
        tick();
        chk("t4 redir_valid", 64'(redir_valid), 64'd1);
        chk("t4 redir idx5", 64'(redir_rob_idx), 64'd5);
        set_ch(0, 0, 0, 32'h820, 32'h824, 32'h824, 5'd6);
        tick();
        chk("t4 still squash", 64'(upd_valid), 64'd0);
        recover_done = 1'b1;
        tick();
        upd_ready = 1'b0;
        // backpressure fill and ordered drain
        for (int j = 0; j < 4; j++) begin
            set_ch(0, 0, 0, 32'h1000 + 32'(32*j), 32'h4, 32'h4, RW'(2*j));
            set_ch(1, 0, 0, 32'h1010 + 32'(32*j), 32'h4, 32'h4, RW'(2*j+1));
            tick();
            if (j == 2) chk("t5 ready at 6", 64'(fu_ready), 64'd1);
        end
        chk("t5 full not ready", 64'(fu_ready), 64'd0);
        set_ch(0, 0, 0, 32'hdead, 32'h4, 32'h4, 5'd20);
        set_ch(1, 0, 0, 32'hdeae, 32'h4, 32'h4, 5'd21);
        tick();
        chk("t5 ignored ready", 64'(fu_ready), 64'd0);
        chk("t5 head kept", 64'(upd_src), 64'h1000);
        upd_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("t5 drain src", 64'(upd_src), 64'(32'h1000 + 32'(16*k)));
            chk("t5 drain ready", 64'(fu_ready), 64'((8 - k) <= 6));
            tick();
        end
        chk("t5 drained", 64'(upd_valid), 64'd0);
        upd_ready = 1'b0;
        // reset while squashing with five entries queued
        set_ch(0, 0, 0, 32'h1, 32'h4, 32'h4, 5'd1);
        set_ch(1, 0, 0, 32'h2, 32'h4, 32'h4, 5'd3);
        tick();
        set_ch(0, 0, 0, 32'h3, 32'h4, 32'h4, 5'd4);
        set_ch(1, 0, 0, 32'h4, 32'h4, 32'h4, 5'd5);
        tick();
        set_ch(0, 1, 0, 32'h5, 32'h40, 32'h8, 5'd2);
        tick();
        chk("t6 redir", 64'(redir_valid), 64'd1);
        rst_n = 1'b0;
        tick();
        chk("t6 upd_valid", 64'(upd_valid), 64'd0);
        chk("t6 redir_valid", 64'(redir_valid), 64'd0);
        chk("t6 fu_ready", 64'(fu_ready), 64'd1);
        rst_n = 1'b1;
        set_ch(0, 0, 0, 32'h700, 32'h704, 32'h704, 5'd20);
        tick();
        chk("t6 idle accept", 64'(upd_valid), 64'd1);
        chk("t6 idle src", 64'(upd_src), 64'h700);
        // random traffic
        for (int c = 0; c < 3000; c++) begin
            rob_head = RW'($urandom);
            base = RW'($urandom);
            recover_done = ($urandom % 6) == 0;
            upd_ready = ($urandom % 3) != 0;
            for (int i = 0; i < NUM_CH; i++) begin
                fu_valid[i] = ($urandom % 4) != 0;
                fu_taken[i] = 1'($urandom);
                fu_pred_taken[i] = (($urandom % 8) == 0) ? ~fu_taken[i] : fu_taken[i];
                fu_src[i*PC_W +: PC_W] = $urandom;
                fu_dst[i*PC_W +: PC_W] = $urandom;
                fu_pred_dst[i*PC_W +: PC_W] = (($urandom % 8) == 0) ? $urandom : fu_dst[i*PC_W +: PC_W];
                fu_rob_idx[i*RW +: RW] = base + RW'(i * 8 + int'($urandom % 8));
            end
            tick();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/resolve_arbiter.md
Name: resolve_arbiter

Overview:
Multi-channel successor to the single-port branch resolve bus. Collects resolve results from NUM_CH branch FUs per cycle and computes each result's correctness against the prediction carried with the instruction. Selects the oldest mispredict for one registered redirect broadcast to ROB, fetch control and instruction buffer. Queues every accepted non-wrong-path resolve into a FIFO that trains the branch predictor. Tracks a squash boundary so that wrong-path resolves arriving after a redirect are discarded.

Parameters:
NUM_CH, 2, number of branch FU resolve channels (1..4)
PC_W, 32, PC width
ROB_IDX_W, 5, ROB index width; age arithmetic is modulo 2^ROB_IDX_W
UPD_DEPTH, 8, predictor-update FIFO depth; must be >= NUM_CH, power of two

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
fu_valid  in  NUM_CH  channel resolve valid
fu_taken  in  NUM_CH  actual direction
fu_src  in  NUM_CH*PC_W  branch PC
fu_dst  in  NUM_CH*PC_W  actual next PC: target if taken, fall-through otherwise
fu_pred_taken  in  NUM_CH  predicted direction
fu_pred_dst  in  NUM_CH*PC_W  predicted next PC
fu_rob_idx  in  NUM_CH*ROB_IDX_W  ROB index of the branch
fu_ready  out  1  all channels may present; common to all channels
rob_head  in  ROB_IDX_W  oldest in-flight ROB index
recover_done  in  1  single-cycle pulse: pipeline recovery after a redirect is complete
redir_valid  out  1  mispredict redirect; single-cycle pulse
redir_dst  out  PC_W  correct fetch PC
redir_rob_idx  out  ROB_IDX_W  mispredicting branch; every ROB entry younger than it is squashed
upd_valid  out  1  predictor update available
upd_src  out  PC_W  update branch PC
upd_dst  out  PC_W  update actual next PC
upd_taken  out  1  update direction
upd_right  out  1  prediction was correct
upd_ready  in  1  predictor consumes the FIFO head

Behaviour:
- Reset (rst_n=0 at a clock edge): all outputs 0 except fu_ready=1; FIFO empty; state IDLE; boundary registers cleared.
- Accepted channel i: fu_valid[i] && fu_ready && not wrong-path.
- right[i] = (taken == pred_taken) && (dst == pred_dst). Not-taken fall-through is compared like any other destination.
- Age: age(x) = (x - rob_head) mod 2^ROB_IDX_W. A smaller age is older. Indices are unique, so ties cannot occur.
- Wrong-path in state SQUASH: age(fu_rob_idx) > age(bnd_idx), where bnd_idx is the latched boundary. Wrong-path inputs are dropped entirely: no redirect, no FIFO write.
- Redirect selection: among accepted channels with right=0, pick the minimum age.
  - The redirect is registered, with 1-cycle latency: redir_* is asserted in cycle T+1 for a mispredict presented in cycle T.
  - Accepted channels younger than the selected branch in the same cycle are also dropped as wrong-path.
- State machine:
  - IDLE -> SQUASH on any redirect; bnd_idx is latched to the redirect index.
  - In SQUASH, a new accepted mispredict is older than bnd_idx by construction. It issues a new redirect and overwrites bnd_idx.
  - SQUASH -> IDLE on recover_done, unless a redirect is issued in the same cycle; the redirect wins and the state stays SQUASH with the new boundary.
  - recover_done in IDLE is ignored.
- FIFO writes:
  - Surviving accepted channels are written in ascending channel order, up to NUM_CH per cycle.
  - upd_right is stored per entry.
  - Entries already in the FIFO are never flushed.
- FIFO pop: upd_valid && upd_ready. upd_* is driven combinationally from the head, and is stable while upd_ready=0.
- Flow control:
  - fu_ready = (free slots >= NUM_CH), computed from the registered count only; a same-cycle pop does not raise it.
  - When fu_ready=0 the FU must hold its inputs; they are not sampled.
- Simultaneous push and pop in one cycle: count' = count + pushes - pop.
- Pointers wrap modulo UPD_DEPTH. Full and empty are distinguished by a separate count register of log2(UPD_DEPTH)+1 bits.
- rob_head is sampled in the same cycle as fu_* for age computation.

Test Plan:
- Reset, then one correct not-taken branch on ch0: pred_taken=0, taken=0, dst=pred_dst=0x104, src=0x100 -> no redir_valid; next cycle upd_valid=1, upd_src=0x100, upd_dst=0x104, upd_taken=0, upd_right=1.
- Dual mispredict, rob_head=30: ch0 rob_idx=1, ch1 rob_idx=31 -> one redirect next cycle with redir_rob_idx=31 (age 1 beats age 3); only the ch1 entry is written to the FIFO.
- Squash filter: after a redirect on idx 10 with rob_head=8, present idx 12 -> dropped (no FIFO write); present mispredicting idx 9 -> redirect to idx 9 and bnd_idx=9; then recover_done -> IDLE, and idx 12 is accepted again.
- Same-cycle recover_done and a new older mispredict -> redir_valid=1 and the state stays SQUASH.
- Backpressure, NUM_CH=2, UPD_DEPTH=8, upd_ready=0: push 3 cycles of 2 -> count=6, fu_ready=1; one more push -> count=8, fu_ready=0 and inputs ignored; raise upd_ready -> FIFO drains in order, and fu_ready returns once count <= 6.
- Reset asserted while in SQUASH with FIFO count 5 -> next cycle upd_valid=0, redir_valid=0, fu_ready=1, state IDLE.
